// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register sequencer: FSM state encoding,
// completion error codes and the per-step engine command bundle.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR_W  = 3'd1;
    localparam logic [2:0] ST_REG     = 3'd2;
    localparam logic [2:0] ST_DATA_W  = 3'd3;
    localparam logic [2:0] ST_RESTART = 3'd4;
    localparam logic [2:0] ST_RD_BYTE = 3'd5;
    localparam logic [2:0] ST_STOP    = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       rw;
        logic [7:0] data;
    } step_cmd_t;

    // Engine command presented for the whole lifetime of a given step.
    function automatic step_cmd_t step_cmd(input logic [2:0] st,
                                           input logic [6:0] dev,
                                           input logic [7:0] regIdx,
                                           input logic [7:0] data);
        step_cmd_t c;
        c = '0;
        case (st)
            ST_ADDR_W:  begin c.start = 1'b1; c.data = {dev, 1'b0}; end
            ST_REG:     c.data = regIdx;
            ST_DATA_W:  c.data = data;
            ST_RESTART: begin c.start = 1'b1; c.data = {dev, 1'b1}; end
            ST_RD_BYTE: c.rw = 1'b1;
            ST_STOP:    c.stop = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i2c_step_timer.sv
// Per-step watchdog: counts cycles while a step is in flight and flags
// expiry once the count reaches WAIT_MAX-1.
module i2c_step_timer #(
    parameter int WAIT_MAX = 3500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = enable && (count_q == LAST);

    // Clear wins so the count restarts on the edge that launches a step.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/i2c_reg_seq.sv
// Register read/write sequencer driving a byte-level I2C engine one step at
// a time, with NACK handling and a per-step watchdog.
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int WAIT_MAX = 3500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req,
    input  logic       wr,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic [1:0] err,
    output logic       busy,
    output logic       m_go,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_rw,
    output logic [7:0] m_dataW,
    input  logic       m_ack,
    input  logic       m_nack,
    input  logic       m_to,
    input  logic [7:0] m_dataR
);

    logic [2:0] state_q, state_d;
    logic       wr_q, wr_d;
    logic [6:0] devAddr_q, devAddr_d;
    logic [7:0] regAddr_q, regAddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] err_q, err_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       go_q, go_d;
    step_cmd_t  cmd_q, cmd_d;

    logic       issue;
    logic       stepActive;
    logic       expired;
    logic       timeoutHit;
    logic       nackHit;
    logic       ackHit;
    logic [2:0] ackNext;

    assign stepActive = (state_q != ST_IDLE) && (state_q != ST_DONE);

    i2c_step_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (issue),
        .enable (stepActive),
        .expired(expired)
    );

    // Engine responses only count once the m_go cycle has passed.
    assign timeoutHit = stepActive && (expired || (!go_q && m_to));
    assign nackHit    = stepActive && !go_q && m_nack;
    assign ackHit     = stepActive && !go_q && m_ack;

    always_comb begin
        ackNext = ST_DONE;
        case (state_q)
            ST_ADDR_W:  ackNext = ST_REG;
            ST_REG:     ackNext = wr_q ? ST_DATA_W : ST_RESTART;
            ST_DATA_W:  ackNext = ST_STOP;
            ST_RESTART: ackNext = ST_RD_BYTE;
            ST_RD_BYTE: ackNext = ST_STOP;
            default:    ackNext = ST_DONE;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        devAddr_d = devAddr_q;
        regAddr_d = regAddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        busy_d    = busy_q;
        cmd_d     = cmd_q;
        done_d    = 1'b0;
        go_d      = 1'b0;
        issue     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (req) begin
                wr_d      = wr;
                devAddr_d = dev_addr;
                regAddr_d = reg_addr;
                wdata_d   = wdata;
                err_d     = ERR_OK;
                busy_d    = 1'b1;
                state_d   = ST_ADDR_W;
                issue     = 1'b1;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (timeoutHit) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_DONE;
        end else if (nackHit) begin
            // A NACK on the STOP step itself just finishes the transaction.
            if (state_q == ST_STOP) begin
                state_d = ST_DONE;
            end else begin
                err_d   = ERR_NACK;
                state_d = ST_STOP;
                issue   = 1'b1;
            end
        end else if (ackHit) begin
            if (state_q == ST_RD_BYTE) begin
                rdata_d = m_dataR;
            end
            state_d = ackNext;
            issue   = (ackNext != ST_DONE);
        end

        if (issue) begin
            go_d  = 1'b1;
            cmd_d = step_cmd(state_d, devAddr_d, regAddr_d, wdata_d);
        end
        if (state_d == ST_DONE) begin
            cmd_d  = '0;
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            devAddr_q <= '0;
            regAddr_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= ERR_OK;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            go_q      <= 1'b0;
            cmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            devAddr_q <= devAddr_d;
            regAddr_q <= regAddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            go_q      <= go_d;
            cmd_q     <= cmd_d;
        end
    end

    assign rdata   = rdata_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign m_go    = go_q;
    assign m_start = cmd_q.start;
    assign m_stop  = cmd_q.stop;
    assign m_rw    = cmd_q.rw;
    assign m_dataW = cmd_q.data;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed self-checking bench for i2c_reg_seq: write, read, NACK, timeout,
// mid-transaction reset and held-request back-to-back transactions.
module tb_i2c_reg_seq;

    logic       clock;
    logic       reset_n;
    logic       req;
    logic       wr;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       done;
    logic [1:0] err;
    logic       busy;
    logic       m_go;
    logic       m_start;
    logic       m_stop;
    logic       m_rw;
    logic [7:0] m_dataW;
    logic       m_ack;
    logic       m_nack;
    logic       m_to;
    logic [7:0] m_dataR;

    int checks   = 0;
    int failures = 0;

    i2c_reg_seq #(
        .WAIT_MAX(100)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .wr      (wr),
        .dev_addr(dev_addr),
        .reg_addr(reg_addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .m_go    (m_go),
        .m_start (m_start),
        .m_stop  (m_stop),
        .m_rw    (m_rw),
        .m_dataW (m_dataW),
        .m_ack   (m_ack),
        .m_nack  (m_nack),
        .m_to    (m_to),
        .m_dataR (m_dataR)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a request at the current negedge; returns on the next negedge,
    // when the first engine step has just been launched.
    task automatic applyStimulus(input logic w, input logic [6:0] dev,
                                 input logic [7:0] ra, input logic [7:0] wd,
                                 input bit holdReq);
        wr       = w;
        dev_addr = dev;
        reg_addr = ra;
        wdata    = wd;
        req      = 1'b1;
        @(negedge clock);
        if (!holdReq) req = 1'b0;
    endtask

    task automatic waitGo(input string tag);
        for (int i = 0; i < 50 && m_go !== 1'b1; i++) @(negedge clock);
        checkOutput({tag, "_go"}, 32'(m_go), 32'd1);
    endtask

    // One engine step: check the launched command, then answer after m_go.
    // resp: 0 = ACK, 1 = NACK.
    task automatic engineStep(input string tag, input logic expStart,
                              input logic expStop, input logic expRw,
                              input logic [7:0] expData, input int resp,
                              input logic [7:0] rdVal);
        waitGo(tag);
        checkOutput({tag, "_cmd"}, {m_start, m_stop, m_rw, m_dataW},
                    {expStart, expStop, expRw, expData});
        @(negedge clock);
        checkOutput({tag, "_go_pulse"}, 32'(m_go), 32'd0);
        checkOutput({tag, "_hold"}, {m_start, m_stop, m_rw, m_dataW},
                    {expStart, expStop, expRw, expData});
        if (resp == 1) m_nack = 1'b1;
        else m_ack = 1'b1;
        m_dataR = rdVal;
        @(negedge clock);
        m_ack   = 1'b0;
        m_nack  = 1'b0;
        m_dataR = 8'h00;
    endtask

    task automatic finishTxn(input string tag, input logic [1:0] expErr,
                             input bit checkRd, input logic [7:0] expRd);
        for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clock);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
        checkOutput({tag, "_busy_drop"}, 32'(busy), 32'd0);
        if (checkRd) checkOutput({tag, "_rdata"}, 32'(rdata), 32'(expRd));
        @(negedge clock);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cycles;
        int goCount;

        clock    = 1'b0;
        reset_n  = 1'b0;
        req      = 1'b0;
        wr       = 1'b0;
        dev_addr = '0;
        reg_addr = '0;
        wdata    = '0;
        m_ack    = 1'b0;
        m_nack   = 1'b0;
        m_to     = 1'b0;
        m_dataR  = '0;

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("rst_outputs",
                    {busy, done, m_go, m_start, m_stop, m_rw, err, rdata, m_dataW},
                    32'd0);
        reset_n = 1'b1;

        // Stray engine responses while idle do nothing
        @(negedge clock);
        m_ack = 1'b1; m_nack = 1'b1; m_to = 1'b1;
        @(negedge clock);
        m_ack = 1'b0; m_nack = 1'b0; m_to = 1'b0;
        @(negedge clock);
        checkOutput("idle_noop", {busy, done, m_go, err}, 32'd0);

        // Register write, inputs scrambled after acceptance
        applyStimulus(1'b1, 7'h50, 8'h10, 8'hA5, 1'b0);
        checkOutput("wr_first_go", 32'(m_go), 32'd1);
        checkOutput("wr_busy", 32'(busy), 32'd1);
        wr = 1'b0; dev_addr = 7'h11; reg_addr = 8'hEE; wdata = 8'h00;
        engineStep("wr_addr", 1'b1, 1'b0, 1'b0, 8'hA0, 0, 8'h00);
        engineStep("wr_reg",  1'b0, 1'b0, 1'b0, 8'h10, 0, 8'h00);
        engineStep("wr_data", 1'b0, 1'b0, 1'b0, 8'hA5, 0, 8'h00);
        engineStep("wr_stop", 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00);
        finishTxn("wr", 2'd0, 1'b0, 8'h00);

        // Register read
        applyStimulus(1'b0, 7'h50, 8'h02, 8'h00, 1'b0);
        engineStep("rd_addr",    1'b1, 1'b0, 1'b0, 8'hA0, 0, 8'h00);
        engineStep("rd_reg",     1'b0, 1'b0, 1'b0, 8'h02, 0, 8'h00);
        engineStep("rd_restart", 1'b1, 1'b0, 1'b0, 8'hA1, 0, 8'h00);
        engineStep("rd_byte",    1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h3C);
        engineStep("rd_stop",    1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00);
        finishTxn("rd", 2'd0, 1'b1, 8'h3C);

        // NACK on address goes straight to STOP
        applyStimulus(1'b0, 7'h2A, 8'h10, 8'h00, 1'b0);
        engineStep("nk_addr", 1'b1, 1'b0, 1'b0, 8'h54, 1, 8'h00);
        engineStep("nk_stop", 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00);
        finishTxn("nk", 2'd1, 1'b0, 8'h00);

        // Silent engine: watchdog fires 100 cycles after m_go, no STOP
        applyStimulus(1'b1, 7'h50, 8'h10, 8'h00, 1'b0);
        waitGo("to_addr");
        cycles  = 0;
        goCount = 0;
        while (done !== 1'b1 && cycles < 200) begin
            @(negedge clock);
            cycles++;
            if (m_go === 1'b1) goCount++;
        end
        checkOutput("to_latency", 32'(cycles), 32'd100);
        checkOutput("to_no_stop", 32'(goCount), 32'd0);
        checkOutput("to_err", 32'(err), 32'd2);
        checkOutput("to_busy_drop", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("to_done_pulse", 32'(done), 32'd0);

        // Reset during the REG step aborts asynchronously
        applyStimulus(1'b1, 7'h50, 8'h10, 8'h5A, 1'b0);
        engineStep("rs_addr", 1'b1, 1'b0, 1'b0, 8'hA0, 0, 8'h00);
        waitGo("rs_reg");
        checkOutput("rs_reg_data", 32'(m_dataW), 32'h10);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rs_async",
                    {busy, done, m_go, m_start, m_stop, m_rw, err, m_dataW},
                    32'd0);
        goCount = 0;
        repeat (2) begin
            @(negedge clock);
            if (done === 1'b1 || m_go === 1'b1) goCount++;
        end
        checkOutput("rs_held_quiet", 32'(goCount), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        applyStimulus(1'b1, 7'h22, 8'h33, 8'h44, 1'b0);
        engineStep("rs2_addr", 1'b1, 1'b0, 1'b0, 8'h44, 0, 8'h00);
        engineStep("rs2_reg",  1'b0, 1'b0, 1'b0, 8'h33, 0, 8'h00);
        engineStep("rs2_data", 1'b0, 1'b0, 1'b0, 8'h44, 0, 8'h00);
        engineStep("rs2_stop", 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00);
        finishTxn("rs2", 2'd0, 1'b0, 8'h00);

        // req held high: exactly two back-to-back transactions
        applyStimulus(1'b1, 7'h50, 8'h01, 8'h11, 1'b1);
        engineStep("hd1_addr", 1'b1, 1'b0, 1'b0, 8'hA0, 0, 8'h00);
        engineStep("hd1_reg",  1'b0, 1'b0, 1'b0, 8'h01, 0, 8'h00);
        engineStep("hd1_data", 1'b0, 1'b0, 1'b0, 8'h11, 0, 8'h00);
        engineStep("hd1_stop", 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00);
        finishTxn("hd1", 2'd0, 1'b0, 8'h00);
        checkOutput("hd_gap_idle", {busy, m_go}, 32'd0);
        @(negedge clock);
        checkOutput("hd2_accept_go", 32'(m_go), 32'd1);
        req = 1'b0;
        engineStep("hd2_addr", 1'b1, 1'b0, 1'b0, 8'hA0, 0, 8'h00);
        engineStep("hd2_reg",  1'b0, 1'b0, 1'b0, 8'h01, 0, 8'h00);
        engineStep("hd2_data", 1'b0, 1'b0, 1'b0, 8'h11, 0, 8'h00);
        engineStep("hd2_stop", 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00);
        finishTxn("hd2", 2'd0, 1'b0, 8'h00);
        goCount = 0;
        repeat (5) begin
            @(negedge clock);
            if (m_go === 1'b1 || busy === 1'b1) goCount++;
        end
        checkOutput("hd_no_third", 32'(goCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 3500000: clock cycles allowed per engine step before a local timeout.
REQ-002 SHALL have port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port req, input, 1: host request; sampled only in IDLE.
REQ-005 SHALL have port wr, input, 1: 1 = register write, 0 = register read.
REQ-006 SHALL have port dev_addr, input, 7: 7-bit slave address.
REQ-007 SHALL have port reg_addr, input, 8: register index.
REQ-008 SHALL have port wdata, input, 8: write data.
REQ-009 SHALL have port rdata, output, 8: read result; valid when done=1 and err=0.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 2: 0 ok, 1 NACK, 2 timeout; valid with done.
REQ-012 SHALL have port busy, output, 1: high from request acceptance until done.
REQ-013 SHALL have engine-side ports m_go, m_start, m_stop, m_rw (outputs, 1 bit each), m_dataW (output, 8 bits), and m_ack, m_nack, m_to (inputs, 1 bit each), plus m_dataR (input, 8 bits).

Function
REQ-014 SHALL sequence one byte-engine step at a time: m_go high for exactly one cycle per step, with m_start, m_stop, m_rw and m_dataW held stable from the m_go cycle until step completion.
REQ-015 SHALL treat the first of m_ack, m_nack or m_to seen after m_go as step completion; simultaneous assertion resolves with priority m_to > m_nack > m_ack.
REQ-016 SHALL use states IDLE, ADDR_W, REG, DATA_W, RESTART, RD_BYTE, STOP, DONE.
REQ-017 Write sequence SHALL be: ADDR_W (start=1, dataW={dev_addr,0}) -> REG (dataW=reg_addr) -> DATA_W (dataW=wdata) -> STOP (stop=1) -> DONE.
REQ-018 Read sequence SHALL be: ADDR_W -> REG -> RESTART (start=1, dataW={dev_addr,1}) -> RD_BYTE (rw=1) -> STOP -> DONE.
REQ-019 SHALL capture m_dataR into rdata on the m_ack that completes RD_BYTE.
REQ-020 SHALL, on m_nack in any addressing or write step, record err=1, skip the remaining steps, and go to STOP.
REQ-021 SHALL, on m_to or an expired local counter in any step, record err=2 and go directly to DONE without issuing STOP.
REQ-022 SHALL keep a per-step counter that is cleared at each m_go and expires when it reaches WAIT_MAX-1.
REQ-023 SHALL latch wr, dev_addr, reg_addr and wdata on acceptance (IDLE with req=1) and ignore later changes to those inputs.
REQ-024 SHALL ignore req while busy is high; requests are neither queued nor acknowledged.
REQ-025 SHALL issue the first m_go exactly 1 cycle after acceptance.
REQ-026 SHALL, in DONE, pulse done for exactly 1 cycle, drop busy in the same cycle, and return to IDLE; a new req is accepted no earlier than the following cycle.
REQ-027 SHALL treat m_ack, m_nack and m_to arriving in IDLE or DONE as no-ops.

Reset
REQ-028 SHALL, while reset_n=0, force: state IDLE; busy, done, m_go, m_start, m_stop, m_rw all 0; err=0; rdata=0; m_dataW=0; counter=0.
REQ-029 Reset asserted mid-transaction SHALL abort immediately, with no STOP issued and no done pulse.

Structure
REQ-030 The state encoding and err codes SHALL be defined in a shared package, i2c_pkg.
REQ-031 The step watchdog SHALL be a sub-module, i2c_step_timer, with inputs clear and enable and output expired.

Verification
REQ-032 Write test: dev 0x50, reg 0x10, data 0xA5, engine ACKs every step -> m_dataW sequence is 0xA0, 0x10, 0xA5, then stop; done is high for 1 cycle; err=0.
REQ-033 Read test: dev 0x50, reg 0x02, engine returns 0x3C -> m_dataW sequence is 0xA0, 0x02, 0xA1; rdata=0x3C; err=0.
REQ-034 NACK on ADDR_W -> next step is STOP; done with err=1; no REG step is issued.
REQ-035 Engine silent with WAIT_MAX=100 -> done 100 cycles after m_go; err=2; no STOP is issued.
REQ-036 reset_n pulled low during REG -> all outputs take their reset values asynchronously; after release, a new req completes normally.
REQ-037 req held high across a whole transaction -> exactly two transactions run back-to-back, with a gap of at least 1 cycle between them.
